// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing RAM, LED register and switches between two masters
module mem_bus_arbiter #(
  parameter int DATA_W = 9,
  parameter int ADDR_W = 9,
  parameter int RAM_AW = 7
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [RAM_AW-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  input  logic [DATA_W-1:0] sw_in,
  output logic [DATA_W-1:0] led_q
);

  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} state_t;

  state_t              state_q, state_d;
  logic                prio_q, prio_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   led_d;
  logic [1:0]          region;
  logic                grant1;
  logic                ack;

  assign region = addr_q[ADDR_W-1:ADDR_W-2];

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      led_q   <= led_d;
    end
  end

  // prio_q names the port that wins a tie; after every ack it flips to the port not served.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    led_d   = led_q;
    grant1  = req1 & (~req0 | prio_q);
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d = grant1;
          we_d    = grant1 ? we1 : we0;
          addr_d  = grant1 ? addr1 : addr0;
          wdata_d = grant1 ? wdata1 : wdata0;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q) begin
          if (region == 2'b01) led_d = wdata_q;
          prio_d  = ~owner_q;
          state_d = IDLE;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        prio_d  = ~owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are suppressed while Resetn is low so an abandoned access never shows an ack.
  always_comb begin
    ack         = 1'b0;
    rdata       = '0;
    ram_address = '0;
    ram_data    = '0;
    ram_wren    = 1'b0;
    if (Resetn) begin
      case (state_q)
        ACCESS: begin
          ram_address = addr_q[RAM_AW-1:0];
          ram_data    = we_q ? wdata_q : '0;
          ram_wren    = we_q && (region == 2'b00);
          ack         = we_q;
        end
        RD_WAIT: begin
          ram_address = addr_q[RAM_AW-1:0];
          ack         = 1'b1;
          case (region)
            2'b00:   rdata = ram_q;
            2'b01:   rdata = led_q;
            default: rdata = sw_in;
          endcase
        end
        default: ;
      endcase
    end
    ack0 = ack & ~owner_q;
    ack1 = ack & owner_q;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - vector table plus scoreboard bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic       Clock = 1'b0;
  logic       Resetn = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [8:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic       ack0, ack1, ram_wren;
  logic [8:0] rdata, ram_data, led_q;
  logic [8:0] ram_q = '0;
  logic [8:0] sw_in = 9'h155;
  logic [6:0] ram_address;

  logic [8:0] mem [0:127];

  typedef struct {
    int         port;
    logic       we;
    logic [8:0] addr;
    logic [8:0] wdata;
    logic [8:0] rd;
    logic       wren;
    logic [8:0] led;
  } vec_t;

  typedef struct {
    int         port;
    logic [8:0] rd;
  } sb_t;

  vec_t vecs [10];
  sb_t  sb [$];
  int   n_vec = 0;
  int   n_miss = 0;

  mem_bus_arbiter #(.DATA_W(9), .ADDR_W(9), .RAM_AW(7)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .sw_in(sw_in), .led_q(led_q)
  );

  always #5 Clock = ~Clock;

  // Synchronous-read 128x9 RAM behind the arbiter.
  always @(posedge Clock) begin
    if (ram_wren) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic expect_ack(input string nm);
    sb_t e;
    if (!(ack0 | ack1)) begin
      chk({nm, " ack present"}, 0, 1);
      return;
    end
    if (sb.size() == 0) begin
      chk({nm, " unexpected ack"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({nm, " ack port"}, {30'b0, ack1, ack0}, (e.port == 1) ? 2 : 1);
    chk({nm, " rdata"}, rdata, e.rd);
  endtask

  task automatic expect_no_ack(input string nm);
    chk({nm, " no ack"}, {30'b0, ack1, ack0}, 0);
  endtask

  task automatic drive(input int p, input logic we, input logic [8:0] a, input logic [8:0] wd);
    if (p == 0) begin
      req0 = 1'b1; we0 = we; addr0 = a; wdata0 = wd;
      we1 = ~we; addr1 = ~a; wdata1 = ~wd;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = a; wdata1 = wd;
      we0 = ~we; addr0 = ~a; wdata0 = ~wd;
    end
  endtask

  task automatic do_reset();
    Resetn = 1'b0; req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
  endtask

  task automatic run_access(input vec_t v, input string nm);
    int lat = 0;
    int wren_cnt = 0;
    sb.push_back('{v.port, v.we ? 9'h000 : v.rd});
    @(negedge Clock);
    drive(v.port, v.we, v.addr, v.wdata);
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge Clock);
      if (ram_wren) wren_cnt++;
      if (ack0 | ack1) begin
        lat = c;
        expect_ack(nm);
        req0 = 1'b0; req1 = 1'b0;
      end
    end
    if (lat == 0) begin
      req0 = 1'b0; req1 = 1'b0;
      void'(sb.pop_back());
    end
    chk({nm, " latency"}, lat, v.we ? 1 : 2);
    chk({nm, " ram_wren cycles"}, wren_cnt, {31'b0, v.wren});
    @(negedge Clock);
    chk({nm, " led_q"}, led_q, v.led);
  endtask

  // Both masters hold req; acks must alternate starting from the port favoured by prio.
  task automatic contend(input int n, input int first, input logic [8:0] a0, input logic [8:0] rd0,
                         input logic [8:0] a1, input logic [8:0] rd1, input string nm);
    int got = 0;
    for (int i = 0; i < n; i++) begin
      if (((i + first) % 2) == 0) sb.push_back('{0, rd0});
      else                        sb.push_back('{1, rd1});
    end
    @(negedge Clock);
    req0 = 1'b1; we0 = 1'b0; addr0 = a0;
    req1 = 1'b1; we1 = 1'b0; addr1 = a1;
    for (int c = 0; c < 10 * n && got < n; c++) begin
      @(negedge Clock);
      if (ack0 | ack1) begin
        got++;
        expect_ack($sformatf("%s #%0d", nm, got));
        if (got == n) begin
          req0 = 1'b0; req1 = 1'b0;
        end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk({nm, " acks seen"}, got, n);
    sb.delete();
    @(negedge Clock);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = '0;

    vecs[0] = '{0, 1'b1, 9'h005, 9'h1A3, 9'h000, 1'b1, 9'h000};
    vecs[1] = '{0, 1'b0, 9'h005, 9'h000, 9'h1A3, 1'b0, 9'h000};
    vecs[2] = '{1, 1'b1, 9'h080, 9'h0F0, 9'h000, 1'b0, 9'h0F0};
    vecs[3] = '{1, 1'b0, 9'h080, 9'h000, 9'h0F0, 1'b0, 9'h0F0};
    vecs[4] = '{0, 1'b0, 9'h1C0, 9'h000, 9'h155, 1'b0, 9'h0F0};
    vecs[5] = '{0, 1'b1, 9'h100, 9'h1FF, 9'h000, 1'b0, 9'h0F0};
    vecs[6] = '{1, 1'b0, 9'h000, 9'h000, 9'h000, 1'b0, 9'h0F0};
    vecs[7] = '{1, 1'b1, 9'h07F, 9'h0C3, 9'h000, 1'b1, 9'h0F0};
    vecs[8] = '{0, 1'b0, 9'h07F, 9'h000, 9'h0C3, 1'b0, 9'h0F0};
    vecs[9] = '{1, 1'b0, 9'h0FF, 9'h000, 9'h0F0, 1'b0, 9'h0F0};

    do_reset();
    @(negedge Clock);
    chk("reset ack", {30'b0, ack1, ack0}, 0);
    chk("reset ram_wren", {31'b0, ram_wren}, 0);
    chk("reset ram_address", {25'b0, ram_address}, 0);
    chk("reset ram_data", ram_data, 0);
    chk("reset led_q", led_q, 0);
    chk("reset rdata", rdata, 0);

    for (int i = 0; i < 10; i++) run_access(vecs[i], $sformatf("vec%0d", i));

    // Continuous contention from reset: 0,1,0,1,0,1 with each port seeing its own data.
    do_reset();
    contend(6, 0, 9'h005, 9'h1A3, 9'h1C0, 9'h155, "rr");

    // Reset in RD_WAIT of a P1 read after prio has been left pointing at P1.
    run_access('{1, 1'b1, 9'h080, 9'h0AA, 9'h000, 1'b0, 9'h0AA}, "pre-led");
    run_access('{0, 1'b0, 9'h005, 9'h000, 9'h1A3, 1'b0, 9'h0AA}, "pre-p0");
    @(negedge Clock);
    drive(1, 1'b0, 9'h080, 9'h000);
    @(posedge Clock);
    @(negedge Clock);
    expect_no_ack("abort access");
    @(posedge Clock);
    #1;
    Resetn = 1'b0; req1 = 1'b0;
    #1;
    expect_no_ack("abort rd_wait");
    @(posedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    expect_no_ack("abort after reset");
    chk("abort led_q", led_q, 0);
    chk("abort ram_address", {25'b0, ram_address}, 0);
    @(negedge Clock);
    expect_no_ack("abort idle");
    contend(2, 0, 9'h005, 9'h1A3, 9'h1C0, 9'h155, "post-reset prio");

    // P1 arrives while P0's read is in ACCESS; P0 keeps req high for a second read.
    sb.push_back('{0, 9'h1A3});
    @(negedge Clock);
    drive(0, 1'b0, 9'h005, 9'h000);
    req1 = 1'b0;
    @(negedge Clock);
    expect_no_ack("late p0 access");
    req1 = 1'b1; we1 = 1'b1; addr1 = 9'h010; wdata1 = 9'h033;
    sb.push_back('{1, 9'h000});
    @(negedge Clock);
    expect_ack("late p0 rd_wait");
    addr0 = 9'h1C0;
    sb.push_back('{0, 9'h155});
    @(negedge Clock);
    expect_no_ack("late idle");
    @(negedge Clock);
    expect_ack("late p1 write");
    chk("late p1 ram_wren", {31'b0, ram_wren}, 1);
    req1 = 1'b0;
    @(negedge Clock);
    expect_no_ack("late idle2");
    @(negedge Clock);
    expect_no_ack("late p0 access2");
    @(negedge Clock);
    expect_ack("late p0 rd_wait2");
    req0 = 1'b0;
    chk("late sb empty", sb.size(), 0);
    sb.delete();
    run_access('{1, 1'b0, 9'h010, 9'h000, 9'h033, 1'b0, 9'h000}, "late readback");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
